// File: rtl/cpc_ram_bank_ctrl.sv
// CPC 512K RAM expansion mapping controller: snoops Gate Array RAM-config writes, drives SRAM
// bank/page address, chip select and RAMDIS. Optional wait state enabled by WAIT_STATE_EN.
module cpc_ram_bank_ctrl #(
  parameter int unsigned NBANK_BITS = 3,
  parameter bit          DECODE_A14 = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RESET_B,
  input  logic                  MREQ_B,
  input  logic                  IOREQ_B,
  input  logic                  WR_B,
  input  logic                  RD_B,
  input  logic                  A15,
  input  logic                  A14,
  input  logic [7:0]            D,
  output logic [NBANK_BITS+1:0] HIADR,
  output logic                  RAMCS_B,
  output logic                  RAMDIS,
  output logic                  READY
);

  typedef enum logic {PortIdle, PortHold} port_st_e;

  port_st_e                r_port_st;
  logic [NBANK_BITS-1:0]   r_cfg_bank;
  logic [2:0]              r_cfg_mode;
  logic [NBANK_BITS+1:0]   r_hiadr;

  logic                    w_port_wr;
  logic [1:0]              w_block;
  logic                    w_mapped;
  logic [1:0]              w_page;
  logic                    w_hit;
  logic [NBANK_BITS+1:0]   w_hiadr_new;

  assign w_port_wr = !IOREQ_B && !WR_B && !A15 && (A14 || !DECODE_A14) && (D[7:6] == 2'b11);

  // One capture per I/O write: HOLD blocks re-capture until the strobe ends.
  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      r_port_st  <= PortIdle;
      r_cfg_bank <= '0;
      r_cfg_mode <= '0;
    end else begin
      case (r_port_st)
        PortIdle: begin
          if (w_port_wr) begin
            r_port_st  <= PortHold;
            r_cfg_bank <= D[NBANK_BITS+2:3];
            r_cfg_mode <= D[2:0];
          end
        end
        PortHold: begin
          if (IOREQ_B || WR_B) r_port_st <= PortIdle;
        end
        default: r_port_st <= PortIdle;
      endcase
    end
  end

  assign w_block = {A15, A14};

  always_comb begin
    w_mapped = 1'b0;
    w_page   = w_block;
    case (r_cfg_mode)
      3'd0: w_mapped = 1'b0;
      // Mode 3 differs from mode 1 only in keeping block 1 internal, which is the default.
      3'd1, 3'd3: begin
        if (w_block == 2'd3) begin
          w_mapped = 1'b1;
          w_page   = 2'd3;
        end
      end
      3'd2: w_mapped = 1'b1;
      default: begin
        if (w_block == 2'd1) begin
          w_mapped = 1'b1;
          w_page   = r_cfg_mode[1:0];
        end
      end
    endcase
  end

  // Refresh (RD_B and WR_B both high) never hits.
  assign w_hit       = w_mapped && !MREQ_B && (!RD_B || !WR_B);
  assign w_hiadr_new = {r_cfg_bank, w_page};

  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      r_hiadr <= '0;
    end else if (w_hit) begin
      r_hiadr <= w_hiadr_new;
    end
  end

  // Hold the last driven address between hits so the SRAM address lines stay quiet.
  assign HIADR   = w_hit ? w_hiadr_new : r_hiadr;
  assign RAMCS_B = !w_hit;
  assign RAMDIS  = w_hit;

`ifdef WAIT_STATE_EN
  typedef enum logic [1:0] {WIdle, WWait, WDone} wait_st_e;

  wait_st_e r_wait_st;
  logic     r_ready;

  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      r_wait_st <= WIdle;
      r_ready   <= 1'b1;
    end else begin
      case (r_wait_st)
        WIdle: begin
          if (w_hit) begin
            r_wait_st <= WWait;
            r_ready   <= 1'b0;
          end
        end
        WWait: begin
          r_wait_st <= WDone;
          r_ready   <= 1'b1;
        end
        WDone: begin
          if (MREQ_B) r_wait_st <= WIdle;
        end
        default: begin
          r_wait_st <= WIdle;
          r_ready   <= 1'b1;
        end
      endcase
    end
  end

  assign READY = r_ready;
`else
  assign READY = 1'b1;
`endif

endmodule

// File: tb/tb_cpc_ram_bank_ctrl.sv
// Directed bench for cpc_ram_bank_ctrl: table of single-cycle bus vectors plus hand-written
// multi-cycle sequences (stretched port write, refresh, wait state, reset mid-access).
module tb_cpc_ram_bank_ctrl;

  logic       CLK;
  logic       RESET_B;
  logic       MREQ_B;
  logic       IOREQ_B;
  logic       WR_B;
  logic       RD_B;
  logic       A15;
  logic       A14;
  logic [7:0] D;
  logic [4:0] HIADR;
  logic       RAMCS_B;
  logic       RAMDIS;
  logic       READY;

  int n_checks;
  int n_fail;

  cpc_ram_bank_ctrl #(
    .NBANK_BITS(3),
    .DECODE_A14(1'b1)
  ) u_dut (
    .CLK    (CLK),
    .RESET_B(RESET_B),
    .MREQ_B (MREQ_B),
    .IOREQ_B(IOREQ_B),
    .WR_B   (WR_B),
    .RD_B   (RD_B),
    .A15    (A15),
    .A14    (A14),
    .D      (D),
    .HIADR  (HIADR),
    .RAMCS_B(RAMCS_B),
    .RAMDIS (RAMDIS),
    .READY  (READY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic       iorq_b;
    logic       mreq_b;
    logic       rd_b;
    logic       wr_b;
    logic [1:0] a;
    logic [7:0] d;
    logic       exp_cs_b;
    logic [4:0] exp_hi;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iorq_b, input logic mreq_b, input logic rd_b,
                       input logic wr_b, input logic [1:0] a, input logic [7:0] d);
    IOREQ_B = iorq_b;
    MREQ_B  = mreq_b;
    RD_B    = rd_b;
    WR_B    = wr_b;
    {A15, A14} = a;
    D       = d;
  endtask

  task automatic add(input logic iorq_b, input logic mreq_b, input logic rd_b, input logic wr_b,
                     input logic [1:0] a, input logic [7:0] d, input logic cs_b,
                     input logic [4:0] hi);
    vec_t v;
    v.iorq_b = iorq_b; v.mreq_b = mreq_b; v.rd_b = rd_b; v.wr_b = wr_b;
    v.a = a; v.d = d; v.exp_cs_b = cs_b; v.exp_hi = hi;
    vecs.push_back(v);
  endtask

  task automatic check_inactive(input string name);
    check({name, " RAMCS_B"}, {7'd0, RAMCS_B}, 8'd1);
    check({name, " RAMDIS"}, {7'd0, RAMDIS}, 8'd0);
    check({name, " HIADR"}, {3'd0, HIADR}, 8'd0);
    check({name, " READY"}, {7'd0, READY}, 8'd1);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    //   iorq mreq rd   wr   a      d      cs_b  hiadr
    add(1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 8'h00, 1'b1, 5'b00000);  // mode 0: C000 internal
    add(1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 8'hC4, 1'b1, 5'b00000);  // port write bank0 mode4
    add(1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 8'h00, 1'b1, 5'b00000);
    add(1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 8'h00, 1'b0, 5'b00000);  // 4000 -> page 0
    add(1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 8'h00, 1'b1, 5'b00000);  // 8000 internal
    add(1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 8'hD2, 1'b1, 5'b00000);  // bank2 mode2
    add(1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 8'h00, 1'b1, 5'b00000);
    add(1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 8'h00, 1'b0, 5'b01011);
    add(1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 8'h00, 1'b1, 5'b01011);  // idle holds HIADR
    add(1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 8'h00, 1'b0, 5'b01000);
    add(1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 8'h00, 1'b0, 5'b01010);  // memory write
    add(1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 8'hF9, 1'b1, 5'b01010);  // bank7 mode1
    add(1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 8'h00, 1'b1, 5'b01010);
    add(1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 8'h00, 1'b0, 5'b11111);
    add(1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 8'h00, 1'b1, 5'b11111);
    add(1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 8'h89, 1'b1, 5'b11111);  // D7:6=10 ignored
    add(1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 8'h00, 1'b1, 5'b11111);
    add(1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 8'h00, 1'b0, 5'b11111);
    add(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 8'hC4, 1'b1, 5'b11111);  // A14=0 not decoded
    add(1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 8'h00, 1'b1, 5'b11111);
    add(1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 8'h00, 1'b1, 5'b11111);
    add(1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 8'hC4, 1'b1, 5'b11111);  // I/O read ignored
    add(1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 8'h00, 1'b1, 5'b11111);
    add(1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 8'h00, 1'b1, 5'b11111);
    add(1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 8'hC3, 1'b1, 5'b11111);  // bank0 mode3
    add(1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 8'h00, 1'b1, 5'b11111);
    add(1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 8'h00, 1'b1, 5'b11111);  // mode 3: block 1 internal
    add(1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 8'h00, 1'b0, 5'b00011);

    drive(1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 8'h00);
    RESET_B = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge CLK);
      #1;
      drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom),
            8'($urandom) | 8'hC0);
      #1;
      check_inactive("reset");
    end
    @(posedge CLK);
    #1;
    drive(1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 8'h00);
    RESET_B = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge CLK);
      #1;
      drive(vecs[i].iorq_b, vecs[i].mreq_b, vecs[i].rd_b, vecs[i].wr_b, vecs[i].a, vecs[i].d);
      @(negedge CLK);
      check($sformatf("vec%0d RAMCS_B", i), {7'd0, RAMCS_B}, {7'd0, vecs[i].exp_cs_b});
      check($sformatf("vec%0d RAMDIS", i), {7'd0, RAMDIS}, {7'd0, ~vecs[i].exp_cs_b});
      check($sformatf("vec%0d HIADR", i), {3'd0, HIADR}, {3'd0, vecs[i].exp_hi});
    end

    // Stretched port write: data changes after the capture edge must be ignored.
    @(posedge CLK);
    #1;
    drive(1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 8'hC5);
    @(posedge CLK);
    #1;
    D = 8'hC7;
    repeat (3) @(posedge CLK);
    #1;
    drive(1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 8'h00);
    @(posedge CLK);
    #1;
    drive(1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 8'h00);
    @(negedge CLK);
    check("stretch RAMCS_B", {7'd0, RAMCS_B}, 8'd0);
    check("stretch HIADR", {3'd0, HIADR}, 8'b0000_0001);

    // Refresh cycle on a mapped block never selects the SRAM.
    @(posedge CLK);
    #1;
    drive(1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 8'h00);
    @(negedge CLK);
    check("refresh RAMCS_B", {7'd0, RAMCS_B}, 8'd1);
    check("refresh RAMDIS", {7'd0, RAMDIS}, 8'd0);

    @(posedge CLK);
    #1;
    drive(1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 8'h00);
    @(posedge CLK);
    #1;
    drive(1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 8'h00);
`ifdef WAIT_STATE_EN
    @(negedge CLK);
    check("wait before edge READY", {7'd0, READY}, 8'd1);
    @(posedge CLK);
    #1;
    check("wait state READY", {7'd0, READY}, 8'd0);
    @(posedge CLK);
    #1;
    check("wait done READY", {7'd0, READY}, 8'd1);
    @(posedge CLK);
    #1;
    check("wait held READY", {7'd0, READY}, 8'd1);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 8'h00);
    @(posedge CLK);
    #1;
    drive(1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK);
      #1;
      check($sformatf("no-hit READY c%0d", i), {7'd0, READY}, 8'd1);
    end
    drive(1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 8'h00);
    @(posedge CLK);
    #1;
    drive(1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 8'h00);
    @(posedge CLK);
    #1;
    check("second wait READY", {7'd0, READY}, 8'd0);
`else
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK);
      #1;
      check($sformatf("hit READY c%0d", i), {7'd0, READY}, 8'd1);
      check($sformatf("hit RAMCS_B c%0d", i), {7'd0, RAMCS_B}, 8'd0);
    end
`endif
    // Asynchronous reset mid-access: outputs must drop without a clock edge.
    #1;
    RESET_B = 1'b0;
    #1;
    check_inactive("async reset");
    @(posedge CLK);
    #1;
    RESET_B = 1'b1;
    @(negedge CLK);
    check("post-reset mode0 RAMCS_B", {7'd0, RAMCS_B}, 8'd1);
    @(posedge CLK);
    #1;
    drive(1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 8'h00);
    @(negedge CLK);
    check("post-reset C000 RAMCS_B", {7'd0, RAMCS_B}, 8'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
